// File: rtl/counter_seq_if.sv
// Command/status bundle for counter_seq.
// The master drives the commands and the prescale value. The slave (the counter)
// returns the count, the terminal-count pulse and the RUN indication.
interface counter_seq_if #(
   parameter int PRE_W = 4
) ();
   logic             start;
   logic             stop;
   logic             step;
   logic             clr;
   logic [PRE_W-1:0] div;
   logic [2:0]       q;
   logic             tc;
   logic             running;

   modport master (
      output start, stop, step, clr, div,
      input  q, tc, running
   );

   modport slave (
      input  start, stop, step, clr, div,
      output q, tc, running
   );
endinterface

// File: rtl/counter_seq.sv
// counter_seq: modulo-MOD counter with an IDLE/RUN/STEP controller and a prescaler.
// All state updates on the falling clock edge. Reset is asynchronous and active-high.
// Command priority on every edge is CLR > STOP > STEP > START.
// Optional feature: define COUNTER_SEQ_AUTOSTOP_EN so that a wrap in RUN returns the
// controller to IDLE on the same edge. Without the macro, RUN continues through wraps.
// The modulus parameter must lie in 2..8 so that the count fits the 3-bit Q output.
module counter_seq #(
   parameter int MOD   = 5,
   parameter int PRE_W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   counter_seq_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_e;

   localparam logic [2:0]       Q_LAST  = 3'(MOD - 1);
   localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

   state_e           state_q, state_d;
   logic [2:0]       q_q, q_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [PRE_W-1:0] div_q, div_d;
   logic             tc_q, tc_d;
   logic             running_q, running_d;
   logic [3:0]       inc_s;

   // Modulo increment. The result is {wrapped, next_count}.
   function automatic logic [3:0] inc_wrap(input logic [2:0] cur);
      logic [3:0] res;
      if (cur == Q_LAST) begin
         res = {1'b1, 3'd0};
      end else begin
         res = {1'b0, cur + 3'd1};
      end
      return res;
   endfunction

   assign inc_s = inc_wrap(q_q);

   // Next-state logic for the controller, the count, the prescaler and TC.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      pre_d   = pre_q;
      div_d   = div_q;
      tc_d    = 1'b0;
      if (bus.clr) begin
         state_d = ST_IDLE;
         q_d     = 3'd0;
         pre_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.stop) begin
                  state_d = ST_IDLE;
               end else if (bus.step) begin
                  state_d = ST_STEP;
               end else if (bus.start) begin
                  // The prescale value is captured here only.
                  // Later changes to DIV are ignored until the next start.
                  div_d   = bus.div;
                  pre_d   = '0;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (bus.stop) begin
                  state_d = ST_IDLE;
                  pre_d   = '0;
               end else if (pre_q == div_q) begin
                  pre_d = '0;
                  q_d   = inc_s[2:0];
                  tc_d  = inc_s[3];
`ifdef COUNTER_SEQ_AUTOSTOP_EN
                  if (inc_s[3]) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_RUN;
                  end
`else
                  state_d = ST_RUN;
`endif
               end else begin
                  pre_d = pre_q + PRE_ONE;
               end
            end
            ST_STEP: begin
               // Commands other than CLR are ignored here. The single increment always completes.
               q_d     = inc_s[2:0];
               tc_d    = inc_s[3];
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               pre_d   = '0;
            end
         endcase
      end
      running_d = (state_d == ST_RUN);
   end

   // State registers: falling-edge clocked, with asynchronous reset.
   always_ff @(negedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         q_q       <= 3'd0;
         pre_q     <= '0;
         div_q     <= '0;
         tc_q      <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         q_q       <= q_d;
         pre_q     <= pre_d;
         div_q     <= div_d;
         tc_q      <= tc_d;
         running_q <= running_d;
      end
   end

   assign bus.q       = q_q;
   assign bus.tc      = tc_q;
   assign bus.running = running_q;

endmodule

// File: tb/tb_counter_seq.sv
// Scoreboard bench for counter_seq.
// The driver applies commands after each rising edge and steps a behavioural model.
// It pushes the expected outputs for the next falling edge into a queue.
// The monitor pops that queue on each rising edge and compares against the DUT.
module tb_counter_seq;
   localparam int MOD   = 5;
   localparam int PRE_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   counter_seq_if #(.PRE_W(PRE_W)) bus ();

   counter_seq #(.MOD(MOD), .PRE_W(PRE_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Expected outputs, packed as {running, tc, q[2:0]}.
   logic [4:0] exp_q[$];

   // Behavioural model.
   // Mode: 0 = idle, 1 = run, 2 = single step.
   // k counts the edges spent in RUN since the start.
   int m_mode = 0;
   int m_q    = 0;
   int m_divr = 0;
   int m_k    = 0;
   bit m_tc   = 1'b0;

   task automatic model_reset();
      m_mode = 0;
      m_q    = 0;
      m_divr = 0;
      m_k    = 0;
      m_tc   = 1'b0;
   endtask

   task automatic model_edge(input bit st, input bit sp, input bit sg, input bit cl, input int dv);
      m_tc = 1'b0;
      if (cl) begin
         m_q    = 0;
         m_mode = 0;
      end else if (m_mode == 1) begin
         if (sp) begin
            m_mode = 0;
         end else begin
            m_k = m_k + 1;
            if (m_k % (m_divr + 1) == 0) begin
               m_q  = (m_q + 1) % MOD;
               m_tc = (m_q == 0);
`ifdef COUNTER_SEQ_AUTOSTOP_EN
               if (m_q == 0) m_mode = 0;
`endif
            end
         end
      end else if (m_mode == 2) begin
         m_q    = (m_q + 1) % MOD;
         m_tc   = (m_q == 0);
         m_mode = 0;
      end else begin
         if (sp) begin
            m_mode = 0;
         end else if (sg) begin
            m_mode = 2;
         end else if (st) begin
            m_divr = dv;
            m_k    = 0;
            m_mode = 1;
         end
      end
   endtask

   // rmode selects the reset behaviour:
   //   0 = none
   //   1 = reset held high across the edge
   //   2 = short reset pulse between the edges
   task automatic drive(input bit st, input bit sp, input bit sg, input bit cl, input int dv, input int rmode);
      logic [4:0] e;
      @(posedge clk);
      #1;
      bus.start = st;
      bus.stop  = sp;
      bus.step  = sg;
      bus.clr   = cl;
      bus.div   = PRE_W'(dv);
      if (rmode == 1) begin
         rst = 1'b1;
         model_reset();
      end else begin
         if (rmode == 2) begin
            rst = 1'b1;
            #2;
            rst = 1'b0;
            model_reset();
         end else begin
            rst = 1'b0;
         end
         model_edge(st, sp, sg, cl, dv);
      end
      e = {(m_mode == 1), m_tc, 3'(m_q)};
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   // Monitor: compares the DUT outputs with the oldest expectation on each rising edge.
   always @(posedge clk) begin
      logic [4:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks = checks + 3;
         if (bus.q !== e[2:0]) begin
            failures = failures + 1;
            $display("FAIL q at %0t: got %0d expected %0d", $time, bus.q, e[2:0]);
         end
         if (bus.tc !== e[3]) begin
            failures = failures + 1;
            $display("FAIL tc at %0t: got %0b expected %0b", $time, bus.tc, e[3]);
         end
         if (bus.running !== e[4]) begin
            failures = failures + 1;
            $display("FAIL running at %0t: got %0b expected %0b", $time, bus.running, e[4]);
         end
      end
   end

   initial begin
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.step  = 1'b0;
      bus.clr   = 1'b0;
      bus.div   = '0;

      // Reset held, then released.
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
      idle(1);

      // DIV=0 with a START pulse: Q counts 1,2,3,4,0,1 and TC marks the wrap.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      idle(7);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);

      // DIV=2 then DIV=0 while in RUN: the increment stays on every 3rd edge.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
      for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);

      // Three STEP pulses from IDLE.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
         idle(1);
      end

      // CLR, STOP and START on the same edge in RUN.
      // Then STOP and START together in IDLE.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
      idle(3);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
      idle(2);

      // Reset pulse between edges while running at Q=3.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      idle(3);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 2);
      idle(2);

      // START held high through RUN, then a STEP ignored in RUN.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, (i == 2), 1'b0, 3, 0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

      // Randomized commands, with occasional reset pulses.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 31) == 0),
               int'($urandom_range(0, 3)), (($urandom_range(0, 99) == 0) ? 2 : 0));
      end

      idle(1);
      @(posedge clk);
      #2;
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         failures = failures + 1;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/counter_seq.md
COUNTER_SEQ -- requirements
Module: counter_seq

Interface
REQ-001 Parameter MOD, default 5: counter modulus; Q counts 0..MOD-1, legal range 2..8.
REQ-002 Parameter PRE_W, default 4: prescaler width; width of DIV.
REQ-003 CLK  input  1  clock; all registers update on the falling edge.
REQ-004 RST  input  1  reset; asynchronous, active-high.
REQ-005 START  input  1  level sampled each edge; requests free-run counting.
REQ-006 STOP  input  1  ends counting.
REQ-007 STEP  input  1  requests exactly one increment.
REQ-008 CLR  input  1  synchronous clear of count and controller.
REQ-009 DIV  input  PRE_W  prescale value; one increment per DIV+1 clocks in RUN.
REQ-010 Q  output  3  current count.
REQ-011 TC  output  1  terminal-count pulse.
REQ-012 RUNNING  output  1  high while in RUN.

Function
REQ-013 The controller SHALL have three states: IDLE, RUN and STEP.
REQ-014 Command priority on any edge SHALL be CLR > STOP > STEP > START.
REQ-015 CLR SHALL force Q=0, prescaler=0, TC=0 and state=IDLE, from any state.
REQ-016 In IDLE, START SHALL latch DIV into DIV_R, clear the prescaler and enter RUN; the first increment SHALL occur DIV_R+1 edges later.
REQ-017 In IDLE, STEP SHALL enter STEP; STEP SHALL increment Q once on the next edge and return to IDLE.
REQ-018 In RUN, the prescaler SHALL count 0..DIV_R; when it equals DIV_R, Q SHALL increment on that edge and the prescaler SHALL return to 0.
REQ-019 DIV changes while in RUN SHALL be ignored until the next START from IDLE.
REQ-020 With DIV_R=0, Q SHALL increment every edge while in RUN.
REQ-021 An increment from Q=MOD-1 SHALL wrap Q to 0 and assert TC for exactly the one cycle in which Q=0.
REQ-022 TC SHALL be 0 in all other cycles, including Q=0 after CLR or reset.
REQ-023 STOP in RUN SHALL enter IDLE, hold Q and clear the prescaler; no increment SHALL occur on that edge.
REQ-024 STEP and START in RUN SHALL be ignored; START, STEP and STOP in STEP SHALL be ignored.
REQ-025 Holding START high in IDLE SHALL enter RUN once; a level held through RUN has no further effect.
REQ-026 RUNNING SHALL be high exactly when state=RUN.

Reset
REQ-027 RST high SHALL immediately force Q=0, TC=0, RUNNING=0, prescaler=0, DIV_R=0 and state=IDLE, independent of CLK.
REQ-028 RST asserted mid-RUN or mid-STEP SHALL abort the operation with no partial increment.
REQ-029 After RST deasserts, the first edge SHALL process commands normally.

Configuration
REQ-030 When the macro COUNTER_SEQ_AUTOSTOP_EN is defined, a wrap in RUN SHALL also move the state to IDLE on the same edge, with TC asserted and RUNNING low in the following cycle.
REQ-031 When COUNTER_SEQ_AUTOSTOP_EN is undefined, RUN SHALL continue through wraps until STOP or CLR.

Verification
REQ-032 Bench SHALL cover reset, then DIV=0 and START pulse -> Q=1,2,3,4,0,1 on successive edges; TC high only in the Q=0 cycle.
REQ-033 Bench SHALL cover DIV=2 and START, then DIV changed to 0 in RUN -> Q increments every 3rd edge throughout.
REQ-034 Bench SHALL cover STEP pulse three times from IDLE -> Q=1,2,3; RUNNING stays 0.
REQ-035 Bench SHALL cover CLR, STOP and START high on the same edge in RUN -> Q=0, IDLE; STOP and START together in IDLE -> remains IDLE.
REQ-036 Bench SHALL cover RST pulse asserted between edges during RUN at Q=3 -> Q=0 and RUNNING=0 before the next edge.
REQ-037 Bench SHALL cover COUNTER_SEQ_AUTOSTOP_EN with DIV=0 and START -> Q reaches 0 with TC=1 and RUNNING=0; Q then holds 0.
